// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings and baud math.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per serial bit, rounded to nearest.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: pulses tick on the last clock of every bit period.
// clr holds the count at PRESET (0 for tx; the receiver presets half a bit).
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PRESET       = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Next count: preset on clear, wrap on tick, else increment.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr)       cnt_d = CW'(PRESET);
    else if (tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, registered serial frame out
// (start, LSB-first data, optional parity, 1 or 2 stop bits).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IW           = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;   // data bit index, reused to count stop bits
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 accept, bit_tick, baud_clr;

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx       = tx_q;
  assign accept   = tx_valid & tx_ready;
  // Counter is parked at 0 while idle so each frame starts on a fresh bit period.
  assign baud_clr = (state_q == IDLE);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (bit_tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; everything past IDLE advances only on bit_tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (bit_tick) state_d = DATA;
      DATA:  if (bit_tick && idx_q == LAST_DATA)
               state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (bit_tick) state_d = STOP;
      STOP:  if (bit_tick && idx_q == LAST_STOP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit index and parity; parity taken from the latched byte during START.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    if (accept) shift_d = tx_data;
    if (state_q == START)
      par_d = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;
    if (bit_tick) begin
      case (state_q)
        DATA: begin
          shift_d = shift_q >> 1;
          idx_d   = (idx_q == LAST_DATA) ? '0 : idx_q + 1'b1;
        end
        STOP:    idx_d = (idx_q == LAST_STOP) ? '0 : idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Line level for the coming cycle, registered so tx never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = par_q;
      default:          tx_d = 1'b1;
    endcase
  end

endmodule
